// File: rtl/btn_pkg.sv
// Shared state encoding and default timing for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DB_ON  = 2'd1,
    S_HELD   = 2'd2,
    S_DB_OFF = 2'd3
  } state_t;

  // Defaults assume the 125 MHz board clock.
  localparam int DEF_CNT_W      = 27;
  localparam int DEF_DB_CYCLES  = 1250000;
  localparam int DEF_REP_DELAY  = 62500000;
  localparam int DEF_REP_PERIOD = 12500000;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchronizer, debounce FSM and auto-repeat timer.
module btn_channel
  import btn_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic rep_en,
  output logic btn_level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_D_LAST = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_P_LAST = CNT_W'(REP_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             sync1, sync2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] dcnt, dcnt_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic             rep_first, rep_first_nxt;
  logic             level_nxt, press_nxt, rel_nxt, rpt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dcnt      <= '0;
      rcnt      <= '0;
      rep_first <= 1'b1;
      btn_level <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      rcnt      <= rcnt_nxt;
      rep_first <= rep_first_nxt;
      btn_level <= level_nxt;
      press     <= press_nxt;
      rel       <= rel_nxt;
      rpt       <= rpt_nxt;
    end
  end

  // rep_first selects the initial delay versus the steady repeat period.
  always_comb begin
    state_nxt     = state;
    dcnt_nxt      = dcnt;
    rcnt_nxt      = rcnt;
    rep_first_nxt = rep_first;
    level_nxt     = btn_level;
    press_nxt     = 1'b0;
    rel_nxt       = 1'b0;
    rpt_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (sync2) begin
          state_nxt = S_DB_ON;
          dcnt_nxt  = '0;
        end
      end
      S_DB_ON: begin
        if (!sync2) begin
          state_nxt = S_IDLE;
        end else if (dcnt == DB_LAST) begin
          state_nxt     = S_HELD;
          level_nxt     = 1'b1;
          press_nxt     = 1'b1;
          rcnt_nxt      = '0;
          rep_first_nxt = 1'b1;
        end else begin
          dcnt_nxt = dcnt + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!sync2) begin
          state_nxt = S_DB_OFF;
          dcnt_nxt  = '0;
        end else if (!rep_en) begin
          rcnt_nxt      = '0;
          rep_first_nxt = 1'b1;
        end else if (rcnt == (rep_first ? REP_D_LAST : REP_P_LAST)) begin
          rpt_nxt       = 1'b1;
          rcnt_nxt      = '0;
          rep_first_nxt = 1'b0;
        end else begin
          rcnt_nxt = rcnt + CNT_ONE;
        end
      end
      S_DB_OFF: begin
        if (sync2) begin
          state_nxt     = S_HELD;
          rcnt_nxt      = '0;
          rep_first_nxt = 1'b1;
        end else if (dcnt == DB_LAST) begin
          state_nxt = S_IDLE;
          level_nxt = 1'b0;
          rel_nxt   = 1'b1;
        end else begin
          dcnt_nxt = dcnt + CNT_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: NUM_BTN independent debounced channels on the fast clock.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] rep_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] rel,
  output logic [NUM_BTN-1:0] rpt
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .CNT_W     (CNT_W),
      .DB_CYCLES (DB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[i]),
      .rep_en   (rep_en[i]),
      .btn_level(btn_level[i]),
      .press    (press[i]),
      .rel      (rel[i]),
      .rpt      (rpt[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table, directed corner sequences, random run vs reference model.
module tb_btn_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_raw, rep_en;
  logic [NB-1:0] btn_level, press, rel, rpt;

  btn_conditioner #(
    .NUM_BTN(NB), .CNT_W(8), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .rep_en(rep_en),
    .btn_level(btn_level), .press(press), .rel(rel), .rpt(rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: run-length debounce plus held-age repeat timer.
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_prev;
  int            m_run[NB];
  int            m_age[NB];
  logic [NB-1:0] e_level, e_press, e_rel, e_rpt;
  int            cnt_press[NB], cnt_rel[NB], cnt_rpt[NB];

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] rep;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rl;
    logic [NB-1:0] rp;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
    e_level = '0; e_press = '0; e_rel = '0; e_rpt = '0;
    for (int c = 0; c < NB; c++) begin
      m_run[c] = 0;
      m_age[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic s;
    for (int c = 0; c < NB; c++) begin
      s = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = btn_raw[c];
      e_press[c] = 1'b0;
      e_rel[c]   = 1'b0;
      e_rpt[c]   = 1'b0;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        m_age[c] = 0;
        if (m_run[c] == DB + 1) begin
          m_lvl[c] = s;
          m_run[c] = 0;
          if (s) e_press[c] = 1'b1;
          else   e_rel[c]   = 1'b1;
        end
      end else begin
        m_run[c] = 0;
        if (m_lvl[c] && rep_en[c] && m_prev[c]) begin
          m_age[c]++;
          if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0))
            e_rpt[c] = 1'b1;
        end else begin
          m_age[c] = 0;
        end
      end
      m_prev[c] = s;
    end
    e_level = m_lvl;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      cnt_press[c] = 0; cnt_rel[c] = 0; cnt_rpt[c] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    else     model_reset();
    #1;
    chk("level", btn_level, e_level);
    chk("press", press, e_press);
    chk("rel", rel, e_rel);
    chk("rpt", rpt, e_rpt);
    for (int c = 0; c < NB; c++) begin
      if (press[c]) cnt_press[c]++;
      if (rel[c])   cnt_rel[c]++;
      if (rpt[c])   cnt_rpt[c]++;
    end
  endtask

  task automatic step_until_press(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!press[ch] && n < 40);
  endtask

  task automatic settle();
    btn_raw = '0;
    rep_en  = '0;
    repeat (15) step();
  endtask

  initial begin
    int n, t, r0, r1;
    int rq[$];
    int exp_rpt[6];

    for (int i = 0; i < 28; i++) begin
      tbl[i].raw = (i < 20) ? 2'b01 : 2'b00;
      tbl[i].rep = 2'b01;
      tbl[i].lvl = (i >= 6 && i < 26) ? 2'b01 : 2'b00;
      tbl[i].prs = (i == 6) ? 2'b01 : 2'b00;
      tbl[i].rl  = (i == 26) ? 2'b01 : 2'b00;
      tbl[i].rp  = (i == 16 || i == 19) ? 2'b01 : 2'b00;
    end
    exp_rpt[0] = 10; exp_rpt[1] = 13; exp_rpt[2] = 16;
    exp_rpt[3] = 19; exp_rpt[4] = 22; exp_rpt[5] = 25;

    rst = 1'b0;
    btn_raw = '0;
    rep_en = '0;
    model_reset();
    clear_counts();
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();

    // Clean press, repeat and release against fixed vectors.
    for (int i = 0; i < 28; i++) begin
      btn_raw = tbl[i].raw;
      rep_en  = tbl[i].rep;
      step();
      chk("tbl_level", btn_level, tbl[i].lvl);
      chk("tbl_press", press, tbl[i].prs);
      chk("tbl_rel", rel, tbl[i].rl);
      chk("tbl_rpt", rpt, tbl[i].rp);
    end
    settle();

    // Bounce: short pulses are swallowed, then a 6-clock hold is accepted once.
    clear_counts();
    btn_raw = 2'b01; repeat (3) step();
    btn_raw = 2'b00; step();
    btn_raw = 2'b01; repeat (3) step();
    btn_raw = 2'b00; repeat (12) step();
    chk_int("bounce_press", cnt_press[0], 0);
    chk_int("bounce_rel", cnt_rel[0], 0);
    clear_counts();
    btn_raw = 2'b01; repeat (6) step();
    btn_raw = 2'b00; repeat (12) step();
    chk_int("hold6_press", cnt_press[0], 1);
    chk_int("hold6_rel", cnt_rel[0], 1);
    chk_int("hold6_ch1_press", cnt_press[1], 0);
    settle();

    // Auto-repeat schedule while held.
    rep_en = 2'b01;
    btn_raw = 2'b01;
    step_until_press(0, n);
    chk_int("rep_press_lat", n, 7);
    rq.delete();
    for (int off = 1; off <= 26; off++) begin
      step();
      if (rpt[0]) rq.push_back(off);
    end
    chk_int("rep_count", rq.size(), 6);
    for (int k = 0; k < 6 && k < rq.size(); k++) chk_int("rep_offset", rq[k], exp_rpt[k]);
    settle();

    // Same hold with repeat disabled.
    rep_en = 2'b00;
    btn_raw = 2'b01;
    step_until_press(0, n);
    clear_counts();
    repeat (30) step();
    chk_int("norep_rpt", cnt_rpt[0], 0);
    settle();

    // Short release glitch while held restarts the repeat delay.
    rep_en = 2'b01;
    btn_raw = 2'b01;
    step_until_press(0, n);
    chk_int("glitch_press_lat", n, 7);
    repeat (5) step();
    clear_counts();
    btn_raw = 2'b00;
    t = 0;
    do begin
      step();
      t++;
      if (t == 2) btn_raw = 2'b01;
    end while (!rpt[0] && t < 40);
    chk_int("glitch_first_rpt", t, 15);
    chk_int("glitch_rel", cnt_rel[0], 0);
    chk_int("glitch_press", cnt_press[0], 0);
    settle();

    // Asynchronous reset in a repeat cycle, then release with the button held.
    rep_en = 2'b01;
    btn_raw = 2'b01;
    step_until_press(0, n);
    repeat (13) step();
    chk("pre_rst_rpt", rpt, 2'b01);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_level", btn_level, 2'b00);
    chk("rst_press", press, 2'b00);
    chk("rst_rel", rel, 2'b00);
    chk("rst_rpt", rpt, 2'b00);
    repeat (2) step();
    rst = 1'b1;
    clear_counts();
    step_until_press(0, n);
    chk_int("rst_rel_press_lat", n, 7);
    chk_int("rst_no_rel", cnt_rel[0], 0);
    settle();

    // Both channels together, released at different times.
    btn_raw = 2'b11;
    n = 0;
    do begin
      step();
      n++;
    end while (press == 2'b00 && n < 40);
    chk("simul_press", press, 2'b11);
    chk_int("simul_press_lat", n, 7);
    repeat (3) step();
    btn_raw = 2'b10;
    t = 0; r0 = -1; r1 = -1;
    while (t < 20) begin
      step();
      t++;
      if (t == 3) btn_raw = 2'b00;
      if (rel[0] && r0 < 0) r0 = t;
      if (rel[1] && r1 < 0) r1 = t;
    end
    chk_int("simul_rel0", r0, 7);
    chk_int("simul_rel1", r1, 10);
    settle();

    // Random levels and repeat enables against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 5) == 0)  btn_raw[c] = ~btn_raw[c];
        if ($urandom_range(0, 39) == 0) rep_en[c]  = ~rep_en[c];
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
